// File: rtl/traffic_light_monitor.sv
// Receive-side checker for the two-road light interface: tracks the phase cycle and latches faults.
// Optional MON_SEG7_EN adds a two-digit seven-segment readout of the sampled countdown.
module traffic_light_monitor #(
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic             tick,
    input  logic [2:0]       a_lights,
    input  logic [2:0]       b_lights,
    input  logic [3:0]       cnt_in,
    input  logic [1:0]       sw,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic             phase_valid,
    output logic [3:0]       dwell,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic [CNT_W-1:0] fault_cnt
`ifdef MON_SEG7_EN
    ,
    output logic [6:0]       seg_tens,
    output logic [6:0]       seg_units
`endif
);

    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_YEL = 3'b101;
    localparam logic [2:0] LAMP_RED = 3'b100;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_CONFLICT = 3'd1;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd2;
    localparam logic [2:0] CODE_ORDER    = 3'd3;
    localparam logic [2:0] CODE_DWELL    = 3'd4;
    localparam logic [2:0] CODE_COUNT    = 3'd5;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         phase_q, phase_d;
    logic               phase_valid_q, phase_valid_d;
    logic [3:0]         dwell_q, dwell_d;
    logic [3:0]         cnt_prev_q, cnt_prev_d;
    logic               over_q, over_d;
    logic               fault_q, fault_d;
    logic [2:0]         fault_code_q, fault_code_d;
    logic [CNT_W-1:0]   fault_cnt_q, fault_cnt_d;

    logic               pair_legal_c;
    logic [1:0]         pair_phase_c;
    logic               override_c;
    logic               flash_c;
    logic               conflict_c;
    logic               illegal_c;
    logic               bad_order_c;
    logic               dwell_err_c;
    logic               cnt_err_c;
    logic [2:0]         code_c;
    logic [3:0]         req_dwell_c;
    logic [3:0]         dwell_inc_c;

    // Lamp-pair decode; override flash is only excused from the conflict rule while sw is nonzero.
    always_comb begin
        pair_legal_c = 1'b1;
        pair_phase_c = 2'd0;
        case ({a_lights, b_lights})
            {LAMP_GRN, LAMP_RED}: pair_phase_c = 2'd0;
            {LAMP_YEL, LAMP_RED}: pair_phase_c = 2'd1;
            {LAMP_RED, LAMP_GRN}: pair_phase_c = 2'd2;
            {LAMP_RED, LAMP_YEL}: pair_phase_c = 2'd3;
            default:              pair_legal_c = 1'b0;
        endcase
        override_c = (sw != 2'b00);
        flash_c    = (a_lights == LAMP_YEL) && (b_lights == LAMP_YEL) && override_c;
        conflict_c = (a_lights != LAMP_RED) && (b_lights != LAMP_RED) && !flash_c;
    end

    // Phase tracker next-state and per-tick checks.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        dwell_d     = dwell_q;
        cnt_prev_d  = cnt_prev_q;
        over_d      = over_q;
        illegal_c   = 1'b0;
        bad_order_c = 1'b0;
        dwell_err_c = 1'b0;
        cnt_err_c   = 1'b0;
        req_dwell_c = phase_q[0] ? 4'(YELLOW_TICKS) : 4'(GREEN_TICKS);
        dwell_inc_c = (dwell_q == 4'hF) ? 4'hF : dwell_q + 4'd1;

        if (tick) begin
            case (state_q)
                ST_SYNC: begin
                    if (override_c) begin
                        state_d = ST_HOLD;
                        dwell_d = 4'd0;
                    end else if (pair_legal_c) begin
                        state_d    = ST_TRACK;
                        phase_d    = pair_phase_c;
                        dwell_d    = 4'd1;
                        cnt_prev_d = cnt_in;
                        over_d     = 1'b0;
                    end else begin
                        illegal_c = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (override_c) begin
                        state_d = ST_HOLD;
                        dwell_d = 4'd0;
                    end else if (!pair_legal_c) begin
                        illegal_c = 1'b1;
                        state_d   = ST_SYNC;
                        dwell_d   = 4'd0;
                    end else if (pair_phase_c == phase_q) begin
                        dwell_d    = dwell_inc_c;
                        cnt_prev_d = cnt_in;
                        cnt_err_c  = (cnt_in != cnt_prev_q - 4'd1);
                        if ((dwell_inc_c > req_dwell_c) && !over_q) begin
                            dwell_err_c = 1'b1;
                            over_d      = 1'b1;
                        end
                    end else begin
                        // Phase change: countdown reloads here, so it is not checked.
                        bad_order_c = (pair_phase_c != phase_q + 2'd1);
                        dwell_err_c = (dwell_q != req_dwell_c);
                        phase_d     = pair_phase_c;
                        dwell_d     = 4'd1;
                        cnt_prev_d  = cnt_in;
                        over_d      = 1'b0;
                    end
                end
                ST_HOLD: begin
                    dwell_d = 4'd0;
                    if (!override_c) begin
                        state_d = ST_SYNC;
                    end
                end
                default: begin
                    state_d = ST_SYNC;
                    dwell_d = 4'd0;
                end
            endcase
        end

        phase_valid_d = (state_d == ST_TRACK);

        code_c = CODE_NONE;
        if (tick) begin
            if (conflict_c)       code_c = CODE_CONFLICT;
            else if (illegal_c)   code_c = CODE_ILLEGAL;
            else if (bad_order_c) code_c = CODE_ORDER;
            else if (dwell_err_c) code_c = CODE_DWELL;
            else if (cnt_err_c)   code_c = CODE_COUNT;
        end
    end

    // Sticky fault registers; a clear on the same cycle as a fault wins.
    always_comb begin
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        fault_cnt_d  = fault_cnt_q;
        if (clr_fault) begin
            fault_d      = 1'b0;
            fault_code_d = CODE_NONE;
            fault_cnt_d  = '0;
        end else if (code_c != CODE_NONE) begin
            fault_d = 1'b1;
            if (!fault_q) begin
                fault_code_d = code_c;
            end
            if (fault_cnt_q != {CNT_W{1'b1}}) begin
                fault_cnt_d = fault_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            state_q       <= ST_SYNC;
            phase_q       <= 2'd0;
            phase_valid_q <= 1'b0;
            dwell_q       <= 4'd0;
            cnt_prev_q    <= 4'd0;
            over_q        <= 1'b0;
            fault_q       <= 1'b0;
            fault_code_q  <= CODE_NONE;
            fault_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            dwell_q       <= dwell_d;
            cnt_prev_q    <= cnt_prev_d;
            over_q        <= over_d;
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            fault_cnt_q   <= fault_cnt_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign dwell       = dwell_q;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;
    assign fault_cnt   = fault_cnt_q;

`ifdef MON_SEG7_EN
    logic [6:0] seg_tens_q, seg_tens_d;
    logic [6:0] seg_units_q, seg_units_d;

    // Segment bit 0 is 'a', bit 6 is 'g'.
    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    always_comb begin
        seg_tens_d  = seg_tens_q;
        seg_units_d = seg_units_q;
        if (tick) begin
            if (state_d == ST_HOLD) begin
                seg_tens_d  = 7'b0000000;
                seg_units_d = 7'b0000000;
            end else if (cnt_in >= 4'd10) begin
                seg_tens_d  = seg7(4'd1);
                seg_units_d = seg7(cnt_in - 4'd10);
            end else begin
                seg_tens_d  = 7'b0000000;
                seg_units_d = seg7(cnt_in);
            end
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            seg_tens_q  <= 7'b0000000;
            seg_units_q <= 7'b0000000;
        end else begin
            seg_tens_q  <= seg_tens_d;
            seg_units_q <= seg_units_d;
        end
    end

    assign seg_tens  = seg_tens_q;
    assign seg_units = seg_units_q;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Scoreboard bench for traffic_light_monitor: expectations queued with stimulus, compared after each tick.
module tb_traffic_light_monitor;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] a_lights = 3'b100;
    logic [2:0] b_lights = 3'b100;
    logic [3:0] cnt_in = 4'd0;
    logic [1:0] sw = 2'b00;
    logic       clr_fault = 1'b0;
    logic [1:0] phase;
    logic       phase_valid;
    logic [3:0] dwell;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;
`ifdef MON_SEG7_EN
    logic [6:0] seg_tens;
    logic [6:0] seg_units;
`endif

    traffic_light_monitor dut (
        .clk        (clk),
        .rst_a      (rst_a),
        .tick       (tick),
        .a_lights   (a_lights),
        .b_lights   (b_lights),
        .cnt_in     (cnt_in),
        .sw         (sw),
        .clr_fault  (clr_fault),
        .phase      (phase),
        .phase_valid(phase_valid),
        .dwell      (dwell),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_cnt  (fault_cnt)
`ifdef MON_SEG7_EN
        ,
        .seg_tens   (seg_tens),
        .seg_units  (seg_units)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [3:0] cnt;
        logic [1:0] sw;
        logic       clr;
    } stim_t;

    stim_t       stim_q[$];
    logic [18:0] sb[$];
    int          tests_run = 0;
    int          fails = 0;

    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] YEL = 3'b101;
    localparam logic [2:0] RED = 3'b100;

    // Expected output vector: {phase, phase_valid, dwell, fault, fault_code, fault_cnt}.
    function automatic logic [18:0] pk(input logic [1:0] ph, input logic v, input logic [3:0] d,
                                       input logic f, input logic [2:0] c, input logic [7:0] n);
        return {ph, v, d, f, c, n};
    endfunction

    function automatic logic [18:0] obs();
        return {phase, phase_valid, dwell, fault, fault_code, fault_cnt};
    endfunction

    function automatic logic [2:0] la(input int ph);
        return (ph == 0) ? GRN : (ph == 1) ? YEL : RED;
    endfunction

    function automatic logic [2:0] lb(input int ph);
        return (ph == 2) ? GRN : (ph == 3) ? YEL : RED;
    endfunction

    task automatic push(input logic [2:0] a, input logic [2:0] b, input logic [3:0] cnt,
                        input logic [1:0] s, input logic clr, input logic [18:0] exp_v);
        stim_t st;
        st.a = a; st.b = b; st.cnt = cnt; st.sw = s; st.clr = clr;
        stim_q.push_back(st);
        sb.push_back(exp_v);
    endtask

    task automatic drive_tick(input stim_t st);
        @(negedge clk);
        a_lights  = st.a;
        b_lights  = st.b;
        cnt_in    = st.cnt;
        sw        = st.sw;
        clr_fault = st.clr;
        tick      = 1'b1;
        @(posedge clk);
        #1;
        tick      = 1'b0;
        clr_fault = 1'b0;
    endtask

    task automatic do_reset();
        stim_q.delete();
        sb.delete();
        @(negedge clk);
        rst_a = 1'b1;
        a_lights = RED; b_lights = RED; cnt_in = 4'd0; sw = 2'b00; tick = 1'b0; clr_fault = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_a = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] e;
        #1;
        sb.push_back(pk(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 8'd0));
        e = sb.pop_front();
        tests_run++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL reset: got %h expected %h", obs(), e);
        end
`ifdef MON_SEG7_EN
        tests_run++;
        if ({seg_tens, seg_units} !== 14'd0) begin
            fails++;
            $display("FAIL reset_seg: got %h expected 0", {seg_tens, seg_units});
        end
`endif
    endtask

    task automatic test_normal_cycle();
        stim_t st;
        logic [18:0] e;
        int n = 0;
        int len;
        do_reset();
        for (int cyc = 0; cyc < 3; cyc++) begin
            for (int ph = 0; ph < 4; ph++) begin
                len = (ph % 2 == 1) ? 4 : 8;
                for (int d = 1; d <= len; d++) begin
                    push(la(ph), lb(ph), 4'(len - d), 2'b00, 1'b0,
                         pk(2'(ph), 1'b1, 4'(d), 1'b0, 3'd0, 8'd0));
                end
            end
        end
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL normal step %0d: got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_conflict();
        stim_t st;
        logic [18:0] e;
        int n = 0;
        do_reset();
        for (int d = 1; d <= 3; d++) begin
            push(GRN, RED, 4'(8 - d), 2'b00, 1'b0, pk(2'd0, 1'b1, 4'(d), 1'b0, 3'd0, 8'd0));
        end
        push(GRN, GRN, 4'd4, 2'b00, 1'b0, pk(2'd0, 1'b0, 4'd0, 1'b1, 3'd1, 8'd1));
        push(YEL, RED, 4'd3, 2'b00, 1'b0, pk(2'd1, 1'b1, 4'd1, 1'b1, 3'd1, 8'd1));
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL conflict step %0d: got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_dwell_overrun();
        stim_t st;
        logic [18:0] e;
        int n = 0;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            if (i <= 8)
                push(GRN, RED, 4'(9 - i), 2'b00, 1'b0, pk(2'd0, 1'b1, 4'(i), 1'b0, 3'd0, 8'd0));
            else
                push(GRN, RED, 4'(9 - i), 2'b00, 1'b0, pk(2'd0, 1'b1, 4'(i), 1'b1, 3'd4, 8'd1));
        end
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL dwell step %0d: got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_bad_order();
        stim_t st;
        logic [18:0] e;
        int n = 0;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            push(GRN, RED, 4'(8 - i), 2'b00, 1'b0, pk(2'd0, 1'b1, 4'(i), 1'b0, 3'd0, 8'd0));
        end
        push(RED, GRN, 4'd7, 2'b00, 1'b0, pk(2'd2, 1'b1, 4'd1, 1'b1, 3'd3, 8'd1));
        for (int j = 2; j <= 8; j++) begin
            push(RED, GRN, 4'(8 - j), 2'b00, 1'b0, pk(2'd2, 1'b1, 4'(j), 1'b1, 3'd3, 8'd1));
        end
        push(RED, YEL, 4'd3, 2'b00, 1'b0, pk(2'd3, 1'b1, 4'd1, 1'b1, 3'd3, 8'd1));
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL order step %0d: got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_countdown_hold();
        stim_t st;
        logic [18:0] e;
        int n = 0;
        do_reset();
        push(GRN, RED, 4'd5, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd1, 1'b0, 3'd0, 8'd0));
        push(GRN, RED, 4'd4, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd2, 1'b0, 3'd0, 8'd0));
        push(GRN, RED, 4'd2, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd3, 1'b1, 3'd5, 8'd1));
        push(YEL, YEL, 4'd0, 2'b01, 1'b0, pk(2'd0, 1'b0, 4'd0, 1'b1, 3'd5, 8'd1));
        push(YEL, YEL, 4'd0, 2'b01, 1'b0, pk(2'd0, 1'b0, 4'd0, 1'b1, 3'd5, 8'd1));
        push(YEL, RED, 4'd3, 2'b00, 1'b0, pk(2'd0, 1'b0, 4'd0, 1'b1, 3'd5, 8'd1));
        push(YEL, RED, 4'd3, 2'b00, 1'b0, pk(2'd1, 1'b1, 4'd1, 1'b1, 3'd5, 8'd1));
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL cnt_hold step %0d: got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_clear();
        stim_t st;
        logic [18:0] e;
        int n = 0;
        do_reset();
        push(GRN, RED, 4'd7, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd1, 1'b0, 3'd0, 8'd0));
        push(GRN, GRN, 4'd6, 2'b00, 1'b1, pk(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 8'd0));
        push(GRN, GRN, 4'd6, 2'b00, 1'b0, pk(2'd0, 1'b0, 4'd0, 1'b1, 3'd1, 8'd1));
        push(GRN, RED, 4'd7, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd1, 1'b1, 3'd1, 8'd1));
        push(GRN, RED, 4'd3, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd2, 1'b1, 3'd1, 8'd2));
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL clear step %0d: got %h expected %h", n, obs(), e);
            end
            n++;
        end
    endtask

    task automatic test_rst_mid();
        stim_t st;
        logic [18:0] e;
        int n = 0;
        do_reset();
        push(GRN, RED, 4'd7, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd1, 1'b0, 3'd0, 8'd0));
        push(GRN, RED, 4'd6, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd2, 1'b0, 3'd0, 8'd0));
        push(GRN, RED, 4'd2, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd3, 1'b1, 3'd5, 8'd1));
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            e = sb.pop_front();
            tests_run++;
            if (obs() !== e) begin
                fails++;
                $display("FAIL rst_mid step %0d: got %h expected %h", n, obs(), e);
            end
            n++;
        end
        #2 rst_a = 1'b1;
        sb.push_back(pk(2'd0, 1'b0, 4'd0, 1'b0, 3'd0, 8'd0));
        #1;
        e = sb.pop_front();
        tests_run++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL rst_mid async: got %h expected %h", obs(), e);
        end
        @(negedge clk);
        rst_a = 1'b0;
        push(RED, GRN, 4'd7, 2'b00, 1'b0, pk(2'd2, 1'b1, 4'd1, 1'b0, 3'd0, 8'd0));
        st = stim_q.pop_front();
        drive_tick(st);
        e = sb.pop_front();
        tests_run++;
        if (obs() !== e) begin
            fails++;
            $display("FAIL rst_mid resume: got %h expected %h", obs(), e);
        end
    endtask

`ifdef MON_SEG7_EN
    task automatic test_seg();
        stim_t st;
        logic [13:0] seg_sb[$];
        logic [13:0] e;
        int n = 0;
        do_reset();
        push(GRN, RED, 4'd11, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd1, 1'b0, 3'd0, 8'd0));
        seg_sb.push_back({7'b0000110, 7'b0000110});
        push(GRN, RED, 4'd10, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd2, 1'b0, 3'd0, 8'd0));
        seg_sb.push_back({7'b0000110, 7'b0111111});
        push(GRN, RED, 4'd3, 2'b00, 1'b0, pk(2'd0, 1'b1, 4'd3, 1'b1, 3'd5, 8'd1));
        seg_sb.push_back({7'b0000000, 7'b1001111});
        push(YEL, YEL, 4'd12, 2'b01, 1'b0, pk(2'd0, 1'b0, 4'd0, 1'b1, 3'd5, 8'd1));
        seg_sb.push_back(14'd0);
        while (stim_q.size() > 0) begin
            st = stim_q.pop_front();
            drive_tick(st);
            void'(sb.pop_front());
            e = seg_sb.pop_front();
            tests_run++;
            if ({seg_tens, seg_units} !== e) begin
                fails++;
                $display("FAIL seg step %0d: got %h expected %h", n, {seg_tens, seg_units}, e);
            end
            n++;
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_normal_cycle();
        test_conflict();
        test_dwell_overrun();
        test_bad_order();
        test_countdown_hold();
        test_clear();
        test_rst_mid();
`ifdef MON_SEG7_EN
        test_seg();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
